seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, sets the number of multiplexed digits (legal range 1..8).
REQ-002 Parameter SCAN_DIV, default 50000, sets the clocks each digit stays enabled (legal range >= 2).
REQ-003 Parameter BLINK_FRAMES, default 64, sets the full scan frames per blink phase (legal range >= 1).
REQ-004 Parameter ACTIVE_LOW, default 1: 1 drives seg, dp and an active-low (lit = 0), 0 drives them active-high.
REQ-005 clk  in  1  single clock for all sequential logic.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 bcd_in  in  4*NUM_DIGITS  digit codes; nibble 0 is least significant digit (LSD).
REQ-008 load  in  1  when high at a rising clk edge, bcd_in, dp_in and blink_en are captured into holding registers.
REQ-009 dp_in  in  NUM_DIGITS  decimal point request per digit.
REQ-010 blink_en  in  NUM_DIGITS  per-digit blink enable.
REQ-011 blank_lz  in  1  leading-zero blanking enable, sampled live.
REQ-012 lamp_test  in  1  all segments lit on the active digit, sampled live.
REQ-013 seg  out  7  segments, seg[6]=a through seg[0]=g.
REQ-014 dp  out  1  decimal point of the active digit.
REQ-015 an  out  NUM_DIGITS  one-hot digit enable (polarity per ACTIVE_LOW).
REQ-016 frame_done  out  1  one-clock pulse when the last digit's slot ends.

Function
REQ-017 Prescaler counts 0..SCAN_DIV-1; on terminal count it wraps to 0 and the digit index advances.
REQ-018 Digit index runs 0,1,..,NUM_DIGITS-1 and wraps to 0; frame_done pulses high for the clock in which the index wraps from NUM_DIGITS-1 to 0.
REQ-019 seg, dp and an are registered; they change exactly one clock after the digit index changes, and never show two digits enabled in the same cycle.
REQ-020 Decode (active-high form, a..g): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47; ACTIVE_LOW inverts seg, dp and an.
REQ-021 Leading-zero blanking: with blank_lz=1, a digit is blanked (seg and dp off) when it and every more-significant digit hold 0 and it is not the LSD; the LSD is never blanked by this rule.
REQ-022 Blink: a phase bit toggles every BLINK_FRAMES frames; while the phase bit = 1, digits with captured blink_en set show seg and dp off, and an still scans.
REQ-023 Priority per digit, highest first: lamp_test (seg=all lit, dp lit), blink-off, leading-zero blank, normal decode.
REQ-024 A load asserted on the same edge as a digit advance takes effect from that new digit's slot; a load held high continuously re-captures every clock.
REQ-025 Changing blank_lz or lamp_test mid-slot takes effect on the next clock's registered output.

Reset
REQ-026 While rst_n=0: prescaler=0, digit index=0, blink phase=0, frame counter=0, holding registers=0, frame_done=0, and all segments, dp and an are driven off (all 1 when ACTIVE_LOW=1).
REQ-027 On the first clock after rst_n rises, digit 0 is enabled and its first slot lasts a full SCAN_DIV clocks.
REQ-028 Reset asserted mid-frame clears all state immediately, with no wait for clk.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1)
REQ-029 load bcd_in=16'h1234 -> an cycles 1110,1101,1011,0111, each for 4 clocks; seg=~7'h33,~7'h79,~7'h6D,~7'h30 in that order; frame_done pulses once per 16 clocks.
REQ-030 bcd_in=16'h0007 with blank_lz=1 -> digits 3..1 show seg=7'h7F and dp=1; digit 0 shows ~7'h70. bcd_in=16'h0000 -> only digit 0 shows ~7'h7E.
REQ-031 blink_en=4'b0001 -> digit 0 is lit for 2 frames (32 clocks), dark for 2 frames, and repeats; the other digits are unaffected.
REQ-032 lamp_test=1 during blink-off with blank_lz=1 and zero data -> every slot shows seg=7'h00 and dp=0.
REQ-033 rst_n pulled low on the 3rd clock of digit 2 -> seg=7'h7F, an=4'hF and dp=1 in the same cycle; after release, digit 0 is enabled for 4 clocks.
REQ-034 load coincident with the digit 1->2 advance changing nibble 2 from 2 to 9 -> digit 2's slot shows ~7'h7B.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment display scanner.
// A prescaler times each digit slot. A digit index walks the digits in turn.
// A frame counter drives the blink phase. Held digit data is decoded, then
// overridden by lamp test, blink and leading-zero blanking, and registered
// onto seg/dp/an with the selected output polarity.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    blank_lz,
  input  logic                    lamp_test,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic          POL        = ACTIVE_LOW;

  // Hex digit to segments, active-high, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hex_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      default: s = 7'h47;
    endcase
    return s;
  endfunction

  logic [PW-1:0]           presc_p0;
  logic [IW-1:0]           idx_p0;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   blink_q;

  logic                    slot_end;
  logic                    frame_end;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic [3:0]              code_p0;
  logic                    dp_req_p0;
  logic                    blink_req_p0;
  logic                    lz_req_p0;
  logic [NUM_DIGITS-1:0]   an_hi_p0;
  logic [6:0]              seg_hi_p0;
  logic                    dp_hi_p0;

  assign slot_end  = (presc_p0 == PRESC_LAST);
  assign frame_end = slot_end && (idx_p0 == IDX_LAST);

  // Slot prescaler, digit index, frame counter, blink phase and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_p0    <= '0;
      idx_p0      <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (slot_end) begin
        presc_p0 <= '0;
        idx_p0   <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end else begin
        presc_p0 <= presc_p0 + 1'b1;
      end
      if (frame_end) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  // Holding registers for the displayed data, refreshed on every load clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      dp_q    <= '0;
      blink_q <= '0;
    end else if (load) begin
      bcd_q   <= bcd_in;
      dp_q    <= dp_in;
      blink_q <= blink_en;
    end
  end

  // Leading-zero mask: a digit qualifies when it and all higher digits are zero; the LSD never does.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (bcd_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_run && (i != 0);
    end
  end

  // Select the active digit's data and resolve lamp test > blink > blanking > decode.
  always_comb begin
    code_p0      = 4'h0;
    dp_req_p0    = 1'b0;
    blink_req_p0 = 1'b0;
    lz_req_p0    = 1'b0;
    an_hi_p0     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_p0 == IW'(i)) begin
        code_p0      = bcd_q[4*i +: 4];
        dp_req_p0    = dp_q[i];
        blink_req_p0 = blink_q[i];
        lz_req_p0    = lz_mask[i];
        an_hi_p0[i]  = 1'b1;
      end
    end
    if (lamp_test) begin
      seg_hi_p0 = 7'h7F;
      dp_hi_p0  = 1'b1;
    end else if (blink_phase && blink_req_p0) begin
      seg_hi_p0 = 7'h00;
      dp_hi_p0  = 1'b0;
    end else if (blank_lz && lz_req_p0) begin
      seg_hi_p0 = 7'h00;
      dp_hi_p0  = 1'b0;
    end else begin
      seg_hi_p0 = hex_decode(code_p0);
      dp_hi_p0  = dp_req_p0;
    end
  end

  // Registered display outputs with the configured polarity; all dark in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end else begin
      seg <= seg_hi_p0 ^ {7{POL}};
      dp  <= dp_hi_p0 ^ POL;
      an  <= an_hi_p0 ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed, table-driven bench for seg7_scan_driver
// with NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_en = '0;
  logic        blank_lz = 1'b0;
  logic        lamp_test = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load), .dp_in(dp_in),
    .blink_en(blink_en), .blank_lz(blank_lz), .lamp_test(lamp_test),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dpv;
    logic        blz;
    logic        lamp;
    logic [27:0] seg_exp;  // {digit3, digit2, digit1, digit0}, active-low
    logic [3:0]  dp_exp;   // active-low per digit
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] an_for(input int d);
    logic [3:0] v;
    v = 4'b0001 << d;
    return ~v;
  endfunction

  // Assert reset, confirm outputs go dark without a clock edge, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_an", 32'(an), 32'hF);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 64);
    check("frame_wait", 32'(frame_done), 32'h1);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b1111};
    vecs[1] = '{16'h0007, 4'b0000, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h0F}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1111};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, 1'b0, {7'h01, 7'h01, 7'h01, 7'h01}, 4'b1111};
    vecs[4] = '{16'hABCD, 4'b0101, 1'b0, 1'b0, {7'h08, 7'h60, 7'h31, 7'h42}, 4'b1010};
    vecs[5] = '{16'h0EF0, 4'b1111, 1'b1, 1'b0, {7'h7F, 7'h30, 7'h38, 7'h01}, 4'b1000};
    vecs[6] = '{16'h0089, 4'b0000, 1'b1, 1'b1, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000};
    vecs[7] = '{16'h5069, 4'b0000, 1'b1, 1'b0, {7'h24, 7'h01, 7'h20, 7'h04}, 4'b1111};

    // Reset, then digit 0 owns the first full slot.
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("first_slot_an", 32'(an), (c <= 4) ? 32'hE : 32'hD);
    end

    // Table: load a vector, align to frame start, check first and last clock of each slot.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      bcd_in = vecs[v].bcd;
      dp_in = vecs[v].dpv;
      blink_en = 4'b0000;
      blank_lz = vecs[v].blz;
      lamp_test = vecs[v].lamp;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_frame();
      for (int d = 0; d < 4; d++) begin
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (j == 0 || j == 3) begin
            check($sformatf("v%0d_d%0d_seg", v, d), 32'(seg), 32'(vecs[v].seg_exp[7*d +: 7]));
            check($sformatf("v%0d_d%0d_dp", v, d), 32'(dp), 32'(vecs[v].dp_exp[d]));
            check($sformatf("v%0d_d%0d_an", v, d), 32'(an), 32'(an_for(d)));
          end
        end
      end
    end

    // Blink on digit 0: lit frames 0-1, dark frames 2-3, lit again 4-5.
    bcd_in = 16'h1234; dp_in = 4'b0000; blink_en = 4'b0001;
    blank_lz = 1'b0; lamp_test = 1'b0; load = 1'b1;
    do_reset();
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      check("blink_frame_done", 32'(frame_done), (c % 16 == 0) ? 32'h1 : 32'h0);
      if ((c - 1) % 16 == 1) begin
        check("blink_d0_seg", 32'(seg), (((c - 1) / 16) inside {2, 3}) ? 32'h7F : 32'h4C);
        check("blink_d0_dp", 32'(dp), 32'h1);
        check("blink_d0_an", 32'(an), 32'hE);
      end
      if ((c - 1) % 16 == 5) begin
        check("blink_d1_seg", 32'(seg), 32'h06);
        check("blink_d1_an", 32'(an), 32'hD);
      end
    end
    load = 1'b0;

    // Lamp test beats blink-off and blanking; dropping it mid-slot takes effect next clock.
    bcd_in = 16'h0000; dp_in = 4'b0000; blink_en = 4'b1111;
    blank_lz = 1'b1; lamp_test = 1'b1; load = 1'b1;
    do_reset();
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      check("lamp_seg", 32'(seg), (c <= 48) ? 32'h00 : 32'h7F);
      check("lamp_dp", 32'(dp), (c <= 48) ? 32'h0 : 32'h1);
      check("lamp_an", 32'(an), 32'(an_for(((c - 1) / 4) % 4)));
      if (c == 48) lamp_test = 1'b0;
    end
    load = 1'b0; blink_en = 4'b0000; blank_lz = 1'b0;

    // Asynchronous reset on the third clock of digit 2, then a clean restart.
    bcd_in = 16'h1234; load = 1'b1;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) load = 1'b0;
    end
    @(posedge clk);
    #1;
    check("pre_rst_an", 32'(an), 32'hB);
    check("pre_rst_seg", 32'(seg), 32'h12);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("post_rst_an", 32'(an), (c <= 4) ? 32'hE : 32'hD);
    end

    // Load on the same edge as the digit 1 -> 2 advance.
    bcd_in = 16'h1234; load = 1'b1;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 8) begin
        check("adv_d1_seg", 32'(seg), 32'h06);
        check("adv_d1_an", 32'(an), 32'hD);
      end
      if (c == 9 || c == 12) begin
        check("adv_d2_seg", 32'(seg), 32'h04);
        check("adv_d2_an", 32'(an), 32'hB);
      end
      if (c == 1) load = 1'b0;
      if (c == 7) begin
        bcd_in = 16'h1934;
        load = 1'b1;
      end
      if (c == 8) load = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
